// File: rtl/clock_ctrl_if.sv
// Button, carry-in and counter-control signals between the front end,
// clock_ctrl and the seconds/minutes/hours counter chain.
interface clock_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_co;
    logic       min_co;
    logic       tick;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic       clr_sec;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, sec_co, min_co,
        input  tick, en_sec, en_min, en_hour, clr_sec, mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, sec_co, min_co,
        output tick, en_sec, en_min, en_hour, clr_sec, mode, blink
    );
endinterface

// File: rtl/clock_ctrl.sv
// Digital-clock sequencer: one-second prescaler, RUN/SET_MIN/SET_HOUR mode
// machine, increment auto-repeat and set-mode blink, all outputs registered.
module clock_ctrl #(
    parameter int DIV   = 50,
    parameter int HOLD  = 16,
    parameter int RPT   = 4,
    parameter int BLINK = 8
) (
    input  logic         clk,
    input  logic         rst,
    clock_ctrl_if.slave  bus
);
    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_MIN  = 2'd1;
    localparam logic [1:0] MODE_SET_HOUR = 2'd2;
    localparam logic [1:0] MODE_BAD      = 2'd3;

    localparam logic [1:0] RS_IDLE   = 2'd0;
    localparam logic [1:0] RS_HOLD   = 2'd1;
    localparam logic [1:0] RS_REPEAT = 2'd2;
    localparam logic [1:0] RS_LOCK   = 2'd3;

    localparam int PW = $clog2(DIV);
    localparam int RW = $clog2((HOLD > RPT) ? HOLD : RPT);
    localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
    localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD - 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(RPT - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    rs_q, rs_d;
    logic [RW-1:0] rc_q, rc_d;
    logic [BW-1:0] bc_q, bc_d;
    logic          inc_prev_q, inc_prev_d;
    logic          blink_q, blink_d;
    logic          tick_q, tick_d;
    logic          en_sec_q, en_sec_d;
    logic          en_min_q, en_min_d;
    logic          en_hour_q, en_hour_d;
    logic          clr_sec_q, clr_sec_d;

    logic run, in_set, mode_change, press, wrap, inc_event;

    always_comb begin
        run         = (mode_q == MODE_RUN);
        in_set      = (mode_q == MODE_SET_MIN) || (mode_q == MODE_SET_HOUR);
        mode_change = bus.btn_mode || (mode_q == MODE_BAD);
        press       = bus.btn_inc && !inc_prev_q;
        wrap        = run && (pre_q == DIV_LAST);
        inc_prev_d  = bus.btn_inc;

        mode_d = mode_q;
        if (mode_q == MODE_BAD) begin
            mode_d = MODE_RUN;
        end else if (bus.btn_mode) begin
            case (mode_q)
                MODE_RUN:     mode_d = MODE_SET_MIN;
                MODE_SET_MIN: mode_d = MODE_SET_HOUR;
                default:      mode_d = MODE_RUN;
            endcase
        end

        // Prescaler sits at 0 outside RUN so RUN always resumes a full period.
        pre_d = (run && !mode_change && !wrap) ? pre_q + PW'(1) : '0;

        // A button held across a mode change stays locked out until released.
        inc_event = 1'b0;
        rs_d      = rs_q;
        rc_d      = rc_q;
        if (mode_change) begin
            rs_d = bus.btn_inc ? RS_LOCK : RS_IDLE;
            rc_d = '0;
        end else if (!bus.btn_inc) begin
            rs_d = RS_IDLE;
            rc_d = '0;
        end else begin
            case (rs_q)
                RS_IDLE: begin
                    if (press && in_set) begin
                        rs_d      = RS_HOLD;
                        rc_d      = '0;
                        inc_event = 1'b1;
                    end
                end
                RS_HOLD: begin
                    if (rc_q == HOLD_LAST) begin
                        rs_d      = RS_REPEAT;
                        rc_d      = '0;
                        inc_event = 1'b1;
                    end else begin
                        rc_d = rc_q + RW'(1);
                    end
                end
                RS_REPEAT: begin
                    if (rc_q == RPT_LAST) begin
                        rc_d      = '0;
                        inc_event = 1'b1;
                    end else begin
                        rc_d = rc_q + RW'(1);
                    end
                end
                default: rs_d = RS_LOCK;
            endcase
        end

        blink_d = blink_q;
        bc_d    = bc_q;
        if (mode_change || run || inc_event) begin
            blink_d = 1'b1;
            bc_d    = '0;
        end else if (bc_q == BLINK_LAST) begin
            blink_d = !blink_q;
            bc_d    = '0;
        end else begin
            bc_d = bc_q + BW'(1);
        end

        tick_d    = wrap;
        en_sec_d  = wrap;
        en_min_d  = (wrap && bus.sec_co) || (inc_event && mode_q == MODE_SET_MIN);
        en_hour_d = (wrap && bus.sec_co && bus.min_co) ||
                    (inc_event && mode_q == MODE_SET_HOUR);
        clr_sec_d = bus.btn_mode && run;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            pre_q      <= '0;
            rs_q       <= RS_IDLE;
            rc_q       <= '0;
            bc_q       <= '0;
            inc_prev_q <= 1'b0;
            blink_q    <= 1'b1;
            tick_q     <= 1'b0;
            en_sec_q   <= 1'b0;
            en_min_q   <= 1'b0;
            en_hour_q  <= 1'b0;
            clr_sec_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            rs_q       <= rs_d;
            rc_q       <= rc_d;
            bc_q       <= bc_d;
            inc_prev_q <= inc_prev_d;
            blink_q    <= blink_d;
            tick_q     <= tick_d;
            en_sec_q   <= en_sec_d;
            en_min_q   <= en_min_d;
            en_hour_q  <= en_hour_d;
            clr_sec_q  <= clr_sec_d;
        end
    end

    assign bus.mode    = mode_q;
    assign bus.blink   = blink_q;
    assign bus.tick    = tick_q;
    assign bus.en_sec  = en_sec_q;
    assign bus.en_min  = en_min_q;
    assign bus.en_hour = en_hour_q;
    assign bus.clr_sec = clr_sec_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with default parameters (DIV=50, HOLD=16,
// RPT=4, BLINK=8); inputs change on the falling edge, outputs are sampled there.
module tb_clock_ctrl;
    localparam int DIV   = 50;
    localparam int HOLD  = 16;
    localparam int RPT   = 4;
    localparam int BLINK = 8;

    localparam logic [7:0] P_NONE = 8'h00;
    localparam logic [7:0] P_TICK = 8'h10;
    localparam logic [7:0] P_SEC  = 8'h08;
    localparam logic [7:0] P_MIN  = 8'h04;
    localparam logic [7:0] P_HOUR = 8'h02;
    localparam logic [7:0] P_CLR  = 8'h01;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] pulse_v;

    clock_ctrl_if bus ();

    clock_ctrl #(.DIV(DIV), .HOLD(HOLD), .RPT(RPT), .BLINK(BLINK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign pulse_v = {3'b000, bus.tick, bus.en_sec, bus.en_min, bus.en_hour, bus.clr_sec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic bm, input logic bi, input logic sc, input logic mc);
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        bus.sec_co   = sc;
        bus.min_co   = mc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] blinkExp(input int j);
        return {7'd0, ((j / BLINK) % 2) == 0};
    endfunction

    initial begin
        int last_ev;
        logic ev;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("reset_pulses", pulse_v, P_NONE);
        checkOutput("reset_mode", {6'd0, bus.mode}, 8'd0);
        checkOutput("reset_blink", {7'd0, bus.blink}, 8'd1);
        rst = 1'b0;

        // Free-running timebase, no carries.
        for (int c = 1; c <= 3 * DIV; c++) begin
            step();
            checkOutput("run_tick", pulse_v, (c % DIV == 0) ? (P_TICK | P_SEC) : P_NONE);
        end
        checkOutput("run_blink", {7'd0, bus.blink}, 8'd1);

        // Carry chaining from sec_co, then sec_co and min_co.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= DIV; c++) begin
            step();
            checkOutput("carry_min", pulse_v, (c == DIV) ? (P_TICK | P_SEC | P_MIN) : P_NONE);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= DIV; c++) begin
            step();
            checkOutput("carry_hour", pulse_v,
                        (c == DIV) ? (P_TICK | P_SEC | P_MIN | P_HOUR) : P_NONE);
        end

        // Mode walk RUN -> SET_MIN -> SET_HOUR -> RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("walk_mode1", {6'd0, bus.mode}, 8'd1);
        checkOutput("walk_clr", pulse_v, P_CLR);
        checkOutput("walk_blink_entry", {7'd0, bus.blink}, 8'd1);
        for (int j = 1; j <= DIV + 5; j++) begin
            step();
            checkOutput("setmin_quiet", pulse_v, P_NONE);
            checkOutput("setmin_blink", {7'd0, bus.blink}, blinkExp(j));
        end
        checkOutput("setmin_mode", {6'd0, bus.mode}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("walk_mode2", {6'd0, bus.mode}, 8'd2);
        checkOutput("walk_noclr2", pulse_v, P_NONE);
        for (int j = 1; j <= 20; j++) begin
            step();
            checkOutput("sethour_quiet", pulse_v, P_NONE);
            checkOutput("sethour_blink", {7'd0, bus.blink}, blinkExp(j));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("walk_mode0", {6'd0, bus.mode}, 8'd0);
        checkOutput("walk_noclr0", pulse_v, P_NONE);
        checkOutput("walk_blink_run", {7'd0, bus.blink}, 8'd1);
        for (int c = 1; c <= DIV; c++) begin
            step();
            checkOutput("resume_tick", pulse_v, (c == DIV) ? (P_TICK | P_SEC) : P_NONE);
        end

        // SET_MIN auto-repeat with btn_inc held 30 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rpt_enter_clr", pulse_v, P_CLR);
        step();
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        last_ev = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            ev = (c == 1) || (c >= 1 + HOLD && ((c - 1 - HOLD) % RPT) == 0);
            if (ev) last_ev = c;
            checkOutput("rpt_en_min", pulse_v, ev ? P_MIN : P_NONE);
            checkOutput("rpt_blink", {7'd0, bus.blink}, blinkExp(c - last_ev));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 31; c <= 36; c++) begin
            step();
            checkOutput("rpt_release", pulse_v, P_NONE);
        end

        // btn_mode and btn_inc press together: mode wins, held button locked out.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("tie_mode", {6'd0, bus.mode}, 8'd2);
        checkOutput("tie_pulse", pulse_v, P_NONE);
        for (int c = 1; c <= 25; c++) begin
            step();
            checkOutput("tie_locked", pulse_v, P_NONE);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("tie_released", pulse_v, P_NONE);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step();
            checkOutput("repress_hour", pulse_v, (c == 1) ? P_HOUR : P_NONE);
            if (c == 5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a SET_HOUR repeat pulse.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 1 + HOLD; c++) begin
            step();
            checkOutput("pre_rst_hour", pulse_v, (c == 1 || c == 1 + HOLD) ? P_HOUR : P_NONE);
        end
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_pulses", pulse_v, P_NONE);
        checkOutput("async_rst_mode", {6'd0, bus.mode}, 8'd0);
        checkOutput("async_rst_blink", {7'd0, bus.blink}, 8'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= DIV; c++) begin
            step();
            checkOutput("post_rst_tick", pulse_v, (c == DIV) ? (P_TICK | P_SEC) : P_NONE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Sequencing controller for the digital-clock counter chain: it generates the one-second timebase and drives the enable and clear inputs of the seconds, minutes and hours counters (count_60 style: rst, clk, en, count, co). It runs a three-mode set/run state machine fed by two pre-debounced buttons. It sits between the button front end and the counter datapath. It holds no time value itself.

## Interface
- DIV, 50: clock cycles per timebase tick; DIV ≥ 4.
- HOLD, 16: cycles btn_inc must stay high after its press before auto-repeat starts; HOLD ≥ 2.
- RPT, 4: auto-repeat period in cycles; RPT ≥ 2.
- BLINK, 8: half-period of blink in set modes, in cycles; BLINK ≥ 1.

- rst  in  1  asynchronous, active-high reset
- clk  in  1  single clock, rising edge
- btn_mode  in  1  one-cycle synchronous pulse that advances the mode
- btn_inc  in  1  level; high while the increment button is held
- sec_co  in  1  seconds counter is at terminal count 59 (level)
- min_co  in  1  minutes counter is at terminal count 59 (level)
- tick  out  1  one-cycle timebase pulse
- en_sec  out  1  one-cycle enable to the seconds counter
- en_min  out  1  one-cycle enable to the minutes counter
- en_hour  out  1  one-cycle enable to the hours counter
- clr_sec  out  1  one-cycle synchronous clear to the seconds counter
- mode  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_HOUR
- blink  out  1  display blanking; 1 = digits visible

## Operation
- Reset state: all outputs 0 except blink = 1. Mode is RUN, the prescaler is 0 and the repeat machine is idle.
- Prescaler: counts 0..DIV-1 and wraps. tick = 1 in the cycle the count equals DIV-1, only in RUN. In the set modes the prescaler is held at 0.
- RUN:
  - en_sec = tick.
  - en_min = tick & sec_co.
  - en_hour = tick & sec_co & min_co.
  - btn_inc is ignored.
- Mode transitions on btn_mode: RUN → SET_MIN → SET_HOUR → RUN. The code value 3 is unreachable; if it is ever reached, the block goes to RUN on the next edge.
- On entering SET_MIN, clr_sec pulses for one cycle. Seconds restart from 00 when RUN resumes.
- SET_MIN: each increment event produces a one-cycle en_min. en_sec = en_hour = 0. Minute wrap does not carry into hours.
- SET_HOUR: each increment event produces a one-cycle en_hour. en_sec = en_min = 0.
- Increment events:
  - Press edge: btn_inc is 1 now and was 0 in the previous sample.
  - First repeat: btn_inc still held HOLD cycles after the press edge.
  - Further repeats: every RPT cycles after that while btn_inc stays high.
  - Releasing btn_inc stops the events and resets the repeat machine.
- Simultaneous btn_mode and btn_inc edge: the mode change wins and the increment is dropped. The repeat machine resets on every mode change. A button held across a mode change produces nothing until it is released and pressed again.
- Blink:
  - RUN: blink = 1.
  - Set modes: blink is forced to 1 on mode entry, then toggles every BLINK cycles.
  - Any increment event forces blink = 1 and restarts its half-period.

## Timing
- All outputs are registered.
- en_*, clr_sec and tick have 1-cycle latency from the sampled condition. The condition is sampled at edge k and the output is high for the cycle after edge k+1.
- First tick and en_sec after reset release: at the DIV-th rising edge. Steady period after that: DIV cycles.
- mode updates one cycle after the btn_mode sample. clr_sec is high in the same cycle mode first reads 1.
- Press at sample k: the en_* pulse follows at k+1. Repeat pulses follow at k+1+HOLD, then k+1+HOLD+n·RPT.
- Returning SET_HOUR → RUN: the prescaler restarts at 0. The first tick comes DIV cycles after mode reads 0.
- Asserting rst mid-operation clears all state immediately, with no clock needed, and drops any pulse in flight.

## Test plan
- Reset, then run 3·DIV cycles with sec_co = min_co = 0: tick and en_sec pulse at cycles DIV, 2·DIV and 3·DIV, one cycle wide. en_min = en_hour = 0.
- RUN with sec_co = 1, min_co = 0, then min_co = 1: en_min is coincident with each en_sec. en_hour pulses together with en_min only once min_co = 1.
- Mode walk with three btn_mode pulses: mode reads 1, 2, 0. clr_sec pulses once, on entry to SET_MIN. tick is absent during the set modes.
- SET_MIN, btn_inc held 30 cycles with HOLD = 16, RPT = 4: en_min pulses at offsets 1, 17, 21, 25 and 29 from the press. en_hour stays 0.
- btn_mode and a btn_inc press in the same cycle, with btn_inc held: mode advances and no en_min/en_hour occurs. After release and re-press, exactly one pulse occurs.
- Assert rst mid-repeat in SET_HOUR: outputs go to their reset values asynchronously (mode = 0, blink = 1). After release, en_sec first appears DIV cycles later.
